// File: rtl/pattern_playback_ctrl_pkg.sv
// Shared game definitions: playback state encoding, LED decode and step timing.
package pattern_playback_ctrl_pkg;

  localparam int CLKS_PER_SEC      = 25_000_000;
  localparam int CLKS_STEP_DEFAULT = CLKS_PER_SEC / 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2,
    DONE = 2'd3
  } play_state_t;

  function automatic logic [3:0] led_decode(input logic [1:0] val);
    return 4'b0001 << val;
  endfunction

endpackage

// File: rtl/pattern_playback_ctrl_if.sv
// Handshake between the game FSM (master) and the pattern playback sequencer (slave).
interface pattern_playback_ctrl_if #(
  parameter int IDX_W = 4
);
  logic             start;
  logic             abort;
  logic [IDX_W-1:0] last_index;
  logic [IDX_W-1:0] rd_index;
  logic [1:0]       rd_data;
  logic [3:0]       led;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, last_index, rd_data,
    input  rd_index, led, busy, done
  );

  modport slave (
    input  start, abort, last_index, rd_data,
    output rd_index, led, busy, done
  );
endinterface

// File: rtl/pattern_playback_ctrl_step_timer.sv
// Loadable down-counter that parks at zero; zero flag drives the step sequencing.
module pattern_step_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pattern_playback_ctrl.sv
// Plays a stored 2-bit pattern onto four LEDs as timed dark-gap / lit steps.
//   state | meaning
//   IDLE  | waiting for start
//   GAP   | LEDs dark before current step
//   SHOW  | LED for current entry lit
//   DONE  | one-cycle completion pulse
module pattern_playback_ctrl
  import pattern_playback_ctrl_pkg::*;
#(
  parameter int CLKS_ON  = CLKS_STEP_DEFAULT,
  parameter int CLKS_OFF = CLKS_STEP_DEFAULT,
  parameter int MAX_LEN  = 11,
  parameter int IDX_W    = $clog2(MAX_LEN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pattern_playback_ctrl_if.slave   bus
);

  localparam int MAX_CLKS = (CLKS_ON > CLKS_OFF) ? CLKS_ON : CLKS_OFF;
  localparam int TMR_W    = (MAX_CLKS > 1) ? $clog2(MAX_CLKS) : 1;
  localparam logic [TMR_W-1:0] ON_LD    = TMR_W'(CLKS_ON - 1);
  localparam logic [TMR_W-1:0] OFF_LD   = TMR_W'(CLKS_OFF - 1);
  localparam logic [IDX_W-1:0] LAST_MAX = IDX_W'(MAX_LEN - 1);

  play_state_t      state, next_state;
  logic [3:0]       led, next_led;
  logic [IDX_W-1:0] rd_index, next_index;
  logic [IDX_W-1:0] last_idx, next_last;
  logic             busy, done;
  logic             tmr_load, tmr_zero;
  logic [TMR_W-1:0] tmr_val;

  pattern_step_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    next_state = state;
    next_led   = led;
    next_index = rd_index;
    next_last  = last_idx;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          next_last  = (bus.last_index > LAST_MAX) ? LAST_MAX : bus.last_index;
          next_index = '0;
          tmr_load   = 1'b1;
          tmr_val    = OFF_LD;
          next_state = GAP;
        end
      end
      GAP: begin
        if (bus.abort) begin
          next_led   = '0;
          next_index = '0;
          next_state = IDLE;
        end else if (tmr_zero) begin
          // Pattern entry is captured only here; later pattern edits don't disturb the lit LED.
          next_led   = led_decode(bus.rd_data);
          tmr_load   = 1'b1;
          tmr_val    = ON_LD;
          next_state = SHOW;
        end
      end
      SHOW: begin
        if (bus.abort) begin
          next_led   = '0;
          next_index = '0;
          next_state = IDLE;
        end else if (tmr_zero) begin
          next_led = '0;
          if (rd_index == last_idx) begin
            next_state = DONE;
          end else begin
            next_index = rd_index + IDX_W'(1);
            tmr_load   = 1'b1;
            tmr_val    = OFF_LD;
            next_state = GAP;
          end
        end
      end
      DONE: begin
        next_index = '0;
        next_state = IDLE;
      end
      default: begin
        next_led   = '0;
        next_index = '0;
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      led      <= '0;
      rd_index <= '0;
      last_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= next_state;
      led      <= next_led;
      rd_index <= next_index;
      last_idx <= next_last;
      busy     <= (next_state == GAP) || (next_state == SHOW);
      done     <= (next_state == DONE);
    end
  end

  assign bus.led      = led;
  assign bus.rd_index = rd_index;
  assign bus.busy     = busy;
  assign bus.done     = done;

endmodule

// File: doc/pattern_playback_ctrl.md
Name: pattern_playback_ctrl

Overview:
Sequencer that plays a stored 2-bit LED pattern onto the 4 game LEDs as timed on/off blinks. It takes over the PATTERN_OFF/PATTERN_SHOW sequencing from the game state machine. The game FSM issues a start pulse and a last-index, then waits for o_Done. The block addresses the game's pattern array through a read-index port and returns a one-cycle completion pulse.

Parameters:
CLKS_ON, 6250000, clocks each LED is lit per step; must be >= 1.
CLKS_OFF, 6250000, clocks of dark gap before each step; must be >= 1.
MAX_LEN, 11, pattern array depth in entries.
IDX_W, $clog2(MAX_LEN), index width.

Ports:
i_Clk  in  1  system clock.
i_Rst_L  in  1  reset, asynchronous, active-low.
i_Start  in  1  start playback, sampled only in IDLE.
i_Abort  in  1  abandon playback; acts in GAP/SHOW.
i_Last_Index  in  IDX_W  index of final entry to play; latched at start.
o_Rd_Index  out  IDX_W  pattern array address.
i_Rd_Data  in  2  pattern entry at o_Rd_Index; combinational read, same cycle.
o_LED  out  4  one-hot LED drive; bit k lit for pattern value k.
o_Busy  out  1  high while in GAP or SHOW.
o_Done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (i_Rst_L low, asynchronous): state=IDLE, o_LED=0, o_Busy=0, o_Done=0, o_Rd_Index=0, timer=0, latched last-index=0.
- The machine has four states: IDLE, GAP, SHOW, DONE. All outputs are registered.
- IDLE:
  - i_Start=1 and i_Abort=0: latch min(i_Last_Index, MAX_LEN-1), set o_Rd_Index=0, load timer=CLKS_OFF-1, go to GAP.
  - i_Abort=1 in the same cycle wins: stay in IDLE.
- GAP:
  - o_LED=0 and the timer decrements each cycle.
  - When timer==0: set o_LED = one-hot(i_Rd_Data), load timer=CLKS_ON-1, go to SHOW.
- SHOW:
  - o_LED is held and the timer decrements.
  - When timer==0: clear o_LED to 0.
  - If o_Rd_Index == latched last-index, go to DONE.
  - Otherwise increment o_Rd_Index, load timer=CLKS_OFF-1, go to GAP.
- DONE: lasts one cycle with o_Done=1. Then o_Rd_Index=0 and the state returns to IDLE.
- o_Busy=1 exactly when the state is GAP or SHOW.
- i_Abort in GAP/SHOW:
  - Next cycle: IDLE, o_LED=0, o_Rd_Index=0, no o_Done.
  - Abort has priority over timer expiry in the same cycle.
- i_Start while busy or in DONE is ignored. It is not queued.
- Timing, with i_Start sampled at cycle 0 and last index N:
  - Step k is dark for cycles 1+k*(OFF+ON) .. k*(OFF+ON)+OFF.
  - Step k is lit for the following ON cycles.
  - o_Done is high at cycle (N+1)*(OFF+ON)+1.
  - Back-to-back: a new i_Start is accepted at cycle (N+1)*(OFF+ON)+2.
- i_Rd_Data is sampled only on the GAP->SHOW transition. Changes to the pattern during SHOW do not alter the lit LED.
- The timer is sized $clog2(max(CLKS_ON,CLKS_OFF)). It never wraps, because it is reloaded on every expiry.
- Reset asserted mid-playback: all outputs return to reset values immediately, with no o_Done.

Decomposition:
- Shared game package holds:
  - state encodings (IDLE=0, GAP=1, SHOW=2, DONE=3);
  - the 2-bit-to-one-hot LED decode function;
  - the default quarter-second step constant CLKS_PER_SEC/4, shared with the game FSM.
- One sub-module, pattern_step_timer, is natural: a loadable down-counter with a load value input, a load strobe, and a zero flag output. It uses the same clock and reset.

Test Plan:
- All tests use CLKS_ON=4, CLKS_OFF=3, MAX_LEN=11.
- Single step: Last_Index=0, pattern[0]=2, Start at cycle 0 -> o_LED=0000 for cycles 1-3, 0100 for cycles 4-7, o_Done=1 at cycle 8 only, o_Busy high for cycles 1-7.
- Three steps: pattern=0,3,1, Last_Index=2 -> o_LED sequence 0001, 1000, 0010 (each 4 cycles after a 3-cycle gap), o_Rd_Index steps 0->1->2, o_Done at cycle 22.
- Abort during second SHOW (cycle 12): cycle 13 shows o_LED=0, o_Busy=0, o_Rd_Index=0; o_Done never pulses; a later Start replays from index 0.
- Start at cycle 5 while busy -> ignored, o_Done still at cycle 8. Start and Abort together in IDLE -> stays IDLE, o_Busy=0.
- Last_Index=15 (over range) -> clamps to 10, plays 11 steps, o_Done at cycle 78.
- i_Rst_L pulsed low asynchronously (between clock edges) mid-SHOW -> o_LED, o_Busy, o_Done are 0 immediately; after release the block sits in IDLE until the next Start.
